spi_slave_if: RTL and testbench
===============================

Name: spi_slave_if

Overview:
- SPI peripheral-side (responder) endpoint for the SPI_driver master: SPI mode 1 (CPOL=0, CPHA=1), MSB first, 8-bit frames, active-low chip select.
- All SPI inputs are oversampled in the system clk domain, so no second clock is needed.
- Provides a one-entry TX buffer and an RX holding register, each with a valid/ready handshake, to local logic.
- Back-to-back bytes within one SPI_EN-low window are supported.

Parameters:
- SYNC_STAGES, 2, synchronizer flop count on SPI_CLK/SPI_MOSI/SPI_EN (legal 2..3).
- IDLE_MISO, 1'b0, level driven on SPI_MISO while SPI_EN is high.

Ports:
- clk  input  1  system clock; must be >= 8x SPI_CLK frequency.
- rst_n  input  1  asynchronous active-low reset.
- SPI_CLK  input  1  serial clock from master, idle low.
- SPI_EN  input  1  chip select from master, active low.
- SPI_MOSI  input  1  serial data from master.
- SPI_MISO  output  1  serial data to master.
- tx_data  input  8  byte to return on the next frame.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  TX buffer empty; transfer on tx_valid&tx_ready.
- rx_data  output  8  last received byte.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ready  input  1  consumer accepts rx_data; transfer on rx_valid&rx_ready.
- busy  output  1  high while a frame is in progress (SPI_EN low).

Behaviour:
- Reset values:
  - SPI_MISO=IDLE_MISO, tx_ready=1, rx_data=0, rx_valid=0, busy=0.
  - Shift registers and bit_cnt are 0.
- Synchronization:
  - SPI_CLK, SPI_EN and SPI_MOSI each pass through SYNC_STAGES flops.
  - Edges are detected from the last two synchronized SPI_CLK samples; CS assert/deassert from the synchronized SPI_EN.
  - Edge-to-action latency is SYNC_STAGES+1 clk.
- FSM: IDLE, ACTIVE.
  - IDLE->ACTIVE on synced SPI_EN falling. On that transition:
    - tx_sh <= TX buffer if full (buffer then marked empty, tx_ready=1 next cycle), else 8'h00.
    - bit_cnt <= 0.
  - ACTIVE->IDLE on synced SPI_EN rising, from any bit position.
    - A partial byte is discarded: no rx_valid, bit_cnt=0.
    - SPI_MISO returns to IDLE_MISO in the same cycle.
- SPI_CLK edge actions, ACTIVE only:
  - Synced rising edge (CPHA=1 launch): SPI_MISO <= tx_sh[7]; tx_sh <= {tx_sh[6:0],1'b0}.
  - Synced falling edge (capture): rx_sh <= {rx_sh[6:0], MOSI_sync}; bit_cnt++.
  - When bit_cnt goes 7->0:
    - rx_data <= the completed byte; rx_valid <= 1 on the next clk.
    - tx_sh reloads from the TX buffer (or 8'h00 if empty) for the next byte in the same frame.
- Edges in IDLE are ignored.
- RX handshake: rx_valid stays high until rx_valid&rx_ready.
  - If a new byte completes while rx_valid=1, rx_data is overwritten (overrun).
  - If rx_ready is high in the same cycle as a byte completes, the new byte wins and rx_valid stays 1.
- TX handshake:
  - tx_ready=0 while the buffer is full.
  - A write accepted in the same cycle the buffer is consumed by a load is legal: the buffer holds the new byte, tx_ready=0.
- busy = (state==ACTIVE).
- bit_cnt is 3 bits and wraps naturally.

Optional Feature:
- Macro: SPI_SLAVE_STATUS_EN.
- When defined, adds output ports status_overrun (1) and status_underrun (1), both sticky and reset to 0.
  - overrun sets when a byte completes while rx_valid=1.
  - underrun sets when tx_sh loads 8'h00 because the TX buffer was empty.
  - Both clear on input status_clr (1), a single-cycle pulse; a set event in the same cycle wins.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Basic frame:
  - Stimulus: preload tx_data=8'hA5; master (CLK_DIV=4) sends 8'h3C.
  - Response: MISO bits 1,0,1,0,0,1,0,1 sampled on SPI_CLK falling; rx_valid=1 with rx_data=8'h3C; tx_ready returns to 1 after CS assert.
- Two-byte frame:
  - Stimulus: SPI_EN held low; TX buffer refilled with 8'h5A after the first load; master sends 8'h11 then 8'h22.
  - Response: MISO returns 8'hA5 then 8'h5A; two rx handshakes, 8'h11 then 8'h22.
- Underrun:
  - Stimulus: no tx_valid before CS.
  - Response: MISO all zeros; rx_data still correct; status_underrun=1 when the macro is enabled.
- Overrun:
  - Stimulus: rx_ready held 0; two bytes 8'h01, 8'h02 received.
  - Response: rx_data=8'h02, rx_valid=1; status_overrun=1 with the macro enabled; after a status_clr pulse it reads 0.
- CS abort:
  - Stimulus: SPI_EN deasserted after 5 falling edges.
  - Response: rx_valid stays 0; MISO=IDLE_MISO; the next full frame 8'hC3 is received correctly.
- Async reset:
  - Stimulus: rst_n asserted mid-byte.
  - Response: all outputs at reset values immediately; IDLE after release; the next frame is received correctly.

Source files
------------

// File: rtl/spi_slave_if.sv
// SPI mode-1 responder (CPOL=0, CPHA=1), 8-bit MSB-first, all SPI pins oversampled on clk; SPI_SLAVE_STATUS_EN adds sticky status flags.
// Latency: SPI edge to action is SYNC_STAGES+1 clk; rx_valid rises the clk after the 8th capture is applied.
// Backpressure: none toward the master; an unread rx byte is overwritten, an empty TX buffer sends 8'h00.
module spi_slave_if #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        IDLE_MISO   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SPI_CLK,
    input  logic       SPI_EN,
    input  logic       SPI_MOSI,
    output logic       SPI_MISO,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
`ifdef SPI_SLAVE_STATUS_EN
    input  logic       status_clr,
    output logic       status_overrun,
    output logic       status_underrun,
`endif
    output logic       busy
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] en_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;
    logic                   en_prev;

    logic sclk_s, en_s, mosi_s;
    logic sclk_rise, sclk_fall, en_fall, en_rise;

    logic [7:0] tx_buf;
    logic       tx_full;
    logic [7:0] tx_sh;
    // Only seven bits need holding; the eighth comes straight from MOSI on the last capture.
    logic [6:0] rx_sh;
    logic [2:0] bit_cnt;

    logic enter, go_idle, launch, capture;
    logic byte_done, load_tx;

    // Chip select syncs to its idle-high level so reset never fakes a CS assert.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            en_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            en_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SPI_CLK};
            en_sync   <= {en_sync[SYNC_STAGES-2:0], SPI_EN};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            en_prev   <= en_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign en_s      = en_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign en_fall   = ~en_s & en_prev;
    assign en_rise   = en_s & ~en_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // CS deassert takes priority over any SPI_CLK edge seen in the same cycle.
    always_comb begin
        state_d = state_q;
        enter   = 1'b0;
        go_idle = 1'b0;
        launch  = 1'b0;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_fall) begin
                    state_d = ST_ACTIVE;
                    enter   = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (en_rise) begin
                    state_d = ST_IDLE;
                    go_idle = 1'b1;
                end else if (sclk_rise) begin
                    launch = 1'b1;
                end else if (sclk_fall) begin
                    capture = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign byte_done = capture && (bit_cnt == 3'd7);
    assign load_tx   = enter | byte_done;
    assign tx_ready  = ~tx_full;
    assign busy      = (state_q == ST_ACTIVE);

    // TX buffer: a write in the same cycle as a load refills it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_buf  <= 8'h00;
            tx_full <= 1'b0;
        end else begin
            if (load_tx) begin
                tx_full <= 1'b0;
            end
            if (tx_valid && tx_ready) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sh    <= 8'h00;
            SPI_MISO <= IDLE_MISO;
        end else begin
            if (load_tx) begin
                tx_sh <= tx_full ? tx_buf : 8'h00;
            end else if (launch) begin
                tx_sh <= {tx_sh[6:0], 1'b0};
            end
            if (launch) begin
                SPI_MISO <= tx_sh[7];
            end else if (go_idle) begin
                SPI_MISO <= IDLE_MISO;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sh   <= 7'h00;
            bit_cnt <= 3'd0;
        end else begin
            if (enter || go_idle) begin
                rx_sh   <= 7'h00;
                bit_cnt <= 3'd0;
            end else if (capture) begin
                rx_sh   <= {rx_sh[5:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // A completing byte beats a same-cycle consume, so rx_valid stays up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
        end else begin
            if (byte_done) begin
                rx_data  <= {rx_sh, mosi_s};
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef SPI_SLAVE_STATUS_EN
    logic overrun_set, underrun_set;

    assign overrun_set  = byte_done & rx_valid;
    assign underrun_set = load_tx & ~tx_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_overrun  <= 1'b0;
            status_underrun <= 1'b0;
        end else begin
            status_overrun  <= overrun_set | (status_overrun & ~status_clr);
            status_underrun <= underrun_set | (status_underrun & ~status_clr);
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: bit-banged mode-1 master, SPI_CLK half period of 4 clk.
module tb_spi_slave_if;

    localparam logic IDLE_MISO = 1'b0;
    localparam int   HALF      = 4;

    logic       clk;
    logic       rst_n;
    logic       SPI_CLK;
    logic       SPI_EN;
    logic       SPI_MOSI;
    logic       SPI_MISO;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       busy;
`ifdef SPI_SLAVE_STATUS_EN
    logic       status_clr;
    logic       status_overrun;
    logic       status_underrun;
`endif

    int errors = 0;
    int checks = 0;
    logic [7:0] got;
    logic [7:0] got2;

    spi_slave_if #(
        .SYNC_STAGES(2),
        .IDLE_MISO  (IDLE_MISO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .SPI_CLK        (SPI_CLK),
        .SPI_EN         (SPI_EN),
        .SPI_MOSI       (SPI_MOSI),
        .SPI_MISO       (SPI_MISO),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
`ifdef SPI_SLAVE_STATUS_EN
        .status_clr     (status_clr),
        .status_overrun (status_overrun),
        .status_underrun(status_underrun),
`endif
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic spi_xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            SPI_CLK  = 1'b1;
            SPI_MOSI = mo[i];
            repeat (HALF) @(negedge clk);
            mi[i]   = SPI_MISO;
            SPI_CLK = 1'b0;
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic cs_low();
        SPI_EN = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_high();
        SPI_EN = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic tx_push(input logic [7:0] d);
        int n;
        n        = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!tx_ready) begin
            errors++;
            $display("FAIL tx_push_timeout: tx_ready=%b required 1 within 50 cycles", tx_ready);
        end
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic rx_pop();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
    endtask

`ifdef SPI_SLAVE_STATUS_EN
    task automatic clr_pulse();
        status_clr = 1'b1;
        @(negedge clk);
        status_clr = 1'b0;
        @(negedge clk);
    endtask
`endif

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (SPI_MISO !== IDLE_MISO) begin errors++; $display("FAIL reset_miso: got %b want %b", SPI_MISO, IDLE_MISO); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef SPI_SLAVE_STATUS_EN
        checks++; if (status_overrun !== 1'b0 || status_underrun !== 1'b0) begin errors++; $display("FAIL reset_status: got %b%b want 00", status_overrun, status_underrun); end
`endif
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic_frame();
        tx_push(8'hA5);
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL basic_tx_full: tx_ready=%b want 0", tx_ready); end
        cs_low();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL basic_tx_ready_after_cs: got %b want 1", tx_ready); end
        spi_xfer(8'h3C, 8, got);
        checks++; if (got !== 8'hA5) begin errors++; $display("FAIL basic_miso: got %h want a5", got); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL basic_rx_valid: got %b want 1", rx_valid); end
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL basic_rx_data: got %h want 3c", rx_data); end
        cs_high();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b want 0", busy); end
        checks++; if (SPI_MISO !== IDLE_MISO) begin errors++; $display("FAIL basic_miso_idle: got %b want %b", SPI_MISO, IDLE_MISO); end
        rx_pop();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_rx_consumed: got %b want 0", rx_valid); end
    endtask

    task automatic test_back_to_back();
        tx_push(8'hA5);
        cs_low();
        tx_push(8'h5A);
        spi_xfer(8'h11, 8, got);
        checks++; if (got !== 8'hA5) begin errors++; $display("FAIL b2b_miso0: got %h want a5", got); end
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin errors++; $display("FAIL b2b_rx0: got v=%b d=%h want v=1 d=11", rx_valid, rx_data); end
        rx_pop();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_pop0: got %b want 0", rx_valid); end
        spi_xfer(8'h22, 8, got2);
        checks++; if (got2 !== 8'h5A) begin errors++; $display("FAIL b2b_miso1: got %h want 5a", got2); end
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h22) begin errors++; $display("FAIL b2b_rx1: got v=%b d=%h want v=1 d=22", rx_valid, rx_data); end
        rx_pop();
        cs_high();
    endtask

    task automatic test_underrun();
`ifdef SPI_SLAVE_STATUS_EN
        clr_pulse();
        checks++; if (status_underrun !== 1'b0) begin errors++; $display("FAIL underrun_clr: got %b want 0", status_underrun); end
`endif
        cs_low();
        spi_xfer(8'h96, 8, got);
        checks++; if (got !== 8'h00) begin errors++; $display("FAIL underrun_miso: got %h want 00", got); end
        checks++; if (rx_data !== 8'h96) begin errors++; $display("FAIL underrun_rx_data: got %h want 96", rx_data); end
`ifdef SPI_SLAVE_STATUS_EN
        checks++; if (status_underrun !== 1'b1) begin errors++; $display("FAIL underrun_flag: got %b want 1", status_underrun); end
`endif
        cs_high();
        rx_pop();
    endtask

    task automatic test_overrun();
`ifdef SPI_SLAVE_STATUS_EN
        clr_pulse();
`endif
        cs_low();
        spi_xfer(8'h01, 8, got);
`ifdef SPI_SLAVE_STATUS_EN
        checks++; if (status_overrun !== 1'b0) begin errors++; $display("FAIL overrun_early: got %b want 0", status_overrun); end
`endif
        spi_xfer(8'h02, 8, got);
        cs_high();
        checks++; if (rx_data !== 8'h02) begin errors++; $display("FAIL overrun_rx_data: got %h want 02", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL overrun_rx_valid: got %b want 1", rx_valid); end
`ifdef SPI_SLAVE_STATUS_EN
        checks++; if (status_overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b want 1", status_overrun); end
        clr_pulse();
        checks++; if (status_overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b want 0", status_overrun); end
`endif
        rx_pop();
    endtask

    task automatic test_cs_abort();
        tx_push(8'hFF);
        cs_low();
        spi_xfer(8'hC3, 5, got);
        checks++; if (SPI_MISO !== 1'b1) begin errors++; $display("FAIL abort_miso_active: got %b want 1", SPI_MISO); end
        cs_high();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL abort_rx_valid: got %b want 0", rx_valid); end
        checks++; if (SPI_MISO !== IDLE_MISO) begin errors++; $display("FAIL abort_miso_idle: got %b want %b", SPI_MISO, IDLE_MISO); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        tx_push(8'hE7);
        cs_low();
        spi_xfer(8'hC3, 8, got);
        checks++; if (got !== 8'hE7) begin errors++; $display("FAIL abort_next_miso: got %h want e7", got); end
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'hC3) begin errors++; $display("FAIL abort_next_rx: got v=%b d=%h want v=1 d=c3", rx_valid, rx_data); end
        cs_high();
        rx_pop();
    endtask

    task automatic test_async_reset();
        tx_push(8'hFF);
        cs_low();
        spi_xfer(8'h55, 3, got);
        SPI_CLK = 1'b1;
        repeat (HALF) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (SPI_MISO !== IDLE_MISO) begin errors++; $display("FAIL areset_miso: got %b want %b", SPI_MISO, IDLE_MISO); end
        checks++; if (rx_data !== 8'h00 || rx_valid !== 1'b0) begin errors++; $display("FAIL areset_rx: got v=%b d=%h want v=0 d=00", rx_valid, rx_data); end
        checks++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL areset_tx_busy: got rdy=%b busy=%b want 1 0", tx_ready, busy); end
        @(negedge clk);
        SPI_CLK = 1'b0;
        SPI_EN  = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (HALF) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_idle: busy=%b want 0", busy); end
        tx_push(8'h3C);
        cs_low();
        spi_xfer(8'hA7, 8, got);
        checks++; if (got !== 8'h3C) begin errors++; $display("FAIL areset_next_miso: got %h want 3c", got); end
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'hA7) begin errors++; $display("FAIL areset_next_rx: got v=%b d=%h want v=1 d=a7", rx_valid, rx_data); end
        cs_high();
        rx_pop();
    endtask

    initial begin
        rst_n    = 1'b0;
        SPI_CLK  = 1'b0;
        SPI_EN   = 1'b1;
        SPI_MOSI = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
`ifdef SPI_SLAVE_STATUS_EN
        status_clr = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_underrun();
        test_overrun();
        test_cs_abort();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
